// File: rtl/icache_if.sv
// Fetch-side and line-fill signals of the instruction cache.
// slave is the cache side; master is the fetcher/memory side.
interface icache_if;
    logic [31:0] addr_in;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;

    modport slave (
        input  addr_in,
        input  mem_valid,
        input  mem_data,
        output instr_valid,
        output instr_out,
        output mem_req,
        output mem_addr
    );

    modport master (
        output addr_in,
        output mem_valid,
        output mem_data,
        input  instr_valid,
        input  instr_out,
        input  mem_req,
        input  mem_addr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, 16-byte lines of 4 words.
// Zero-latency hit; misses refill a whole line over 4 beats.
module icache #(
    parameter int INDEX_W = 6
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    icache_if.slave   bus
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 28 - INDEX_W;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         beat_q, beat_d;
    logic [31:0]        fill_addr_q, fill_addr_d;
    logic               mem_req_q, mem_req_d;
    logic [LINES-1:0]   valid_q, valid_d;

    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [31:0]        data_q [LINES][4];

    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [1:0]         req_word;
    logic [INDEX_W-1:0] fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               hit;
    logic               beat_we;
    logic               fill_done;
    logic               unused_bits;

    assign req_word = bus.addr_in[3:2];
    assign req_idx  = bus.addr_in[4+INDEX_W-1:4];
    assign req_tag  = bus.addr_in[31:4+INDEX_W];
    assign fill_idx = fill_addr_q[4+INDEX_W-1:4];
    assign fill_tag = fill_addr_q[31:4+INDEX_W];

    assign unused_bits = ^{bus.addr_in[1:0], fill_addr_q[3:0]};

    assign hit = (state_q == IDLE) && rdy && valid_q[req_idx]
                 && (tag_q[req_idx] == req_tag);

    assign bus.instr_valid = hit;
    assign bus.instr_out   = data_q[req_idx][req_word];
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = fill_addr_q;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        fill_addr_d = fill_addr_q;
        mem_req_d   = mem_req_q;
        valid_d     = valid_q;
        beat_we     = 1'b0;
        fill_done   = 1'b0;
        if (rdy) begin
            unique case (state_q)
                IDLE: begin
                    if (!hit) begin
                        fill_addr_d      = {bus.addr_in[31:4], 4'h0};
                        valid_d[req_idx] = 1'b0;
                        beat_d           = 2'd0;
                        state_d          = FILL;
                        mem_req_d        = 1'b1;
                    end
                end
                FILL: begin
                    if (bus.mem_valid) begin
                        beat_we = 1'b1;
                        beat_d  = beat_q + 2'd1;
                        // Last beat: line becomes usable next cycle
                        if (beat_q == 2'd3) begin
                            fill_done         = 1'b1;
                            valid_d[fill_idx] = 1'b1;
                            state_d           = IDLE;
                            mem_req_d         = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= 2'd0;
            fill_addr_q <= 32'h0;
            mem_req_q   <= 1'b0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            fill_addr_q <= fill_addr_d;
            mem_req_q   <= mem_req_d;
            valid_q     <= valid_d;
        end
    end

    // Tag and data arrays carry no reset; valid bits guard them
    always_ff @(posedge clk) begin
        if (!rst && beat_we) begin
            data_q[fill_idx][beat_q] <= bus.mem_data;
        end
        if (!rst && fill_done) begin
            tag_q[fill_idx] <= fill_tag;
        end
    end
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: per-cycle expectations go through
// a scoreboard queue; hit vectors come from a table.
module tb_icache;
    logic clk = 1'b0;
    logic rst;
    logic rdy;

    icache_if bus ();

    icache #(.INDEX_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       nm;
        logic        ev;
        logic [31:0] ed;
        logic        ereq;
        logic [31:0] eaddr;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic        mv;
        logic [31:0] md;
        logic [31:0] ed;
    } vec_t;

    exp_t        sb [$];
    vec_t        tbl [6];
    logic [31:0] cur_base;

    function automatic logic [31:0] bd(input logic [31:0] base,
                                       input int i);
        if (base == 32'h0000_1000) begin
            return 32'h1111_1111 * 32'(i + 1);
        end
        return {base[15:4], 4'(i), 16'hC0DE};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic [31:0] a, input logic r,
                       input logic mv, input logic [31:0] md,
                       input string nm, input logic ev,
                       input logic [31:0] ed, input logic ereq);
        exp_t e;
        bus.addr_in   = a;
        rdy           = r;
        bus.mem_valid = mv;
        bus.mem_data  = md;
        e.nm    = nm;
        e.ev    = ev;
        e.ed    = ed;
        e.ereq  = ereq;
        e.eaddr = cur_base;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk({e.nm, ".valid"}, 32'(bus.instr_valid), 32'(e.ev));
        if (e.ev) chk({e.nm, ".data"}, bus.instr_out, e.ed);
        chk({e.nm, ".req"}, 32'(bus.mem_req), 32'(e.ereq));
        chk({e.nm, ".maddr"}, bus.mem_addr, e.eaddr);
        @(posedge clk);
        #1;
    endtask

    task automatic miss(input logic [31:0] a, input string nm);
        cyc(a, 1'b1, 1'b0, 32'h0, nm, 1'b0, 32'h0, 1'b0);
        cur_base = {a[31:4], 4'h0};
    endtask

    task automatic hit(input logic [31:0] a, input logic [31:0] ed,
                       input string nm);
        cyc(a, 1'b1, 1'b0, 32'h0, nm, 1'b1, ed, 1'b0);
    endtask

    task automatic fill(input logic [31:0] a, input logic [3:0] gaps,
                        input int stall);
        for (int i = 0; i < 4; i++) begin
            if (gaps[i]) begin
                cyc(a, 1'b1, 1'b0, 32'h0, $sformatf("gap%0d", i),
                    1'b0, 32'h0, 1'b1);
            end
            if (i == 1) begin
                repeat (stall) begin
                    cyc(a, 1'b0, 1'b1, 32'hBAD0_BAD0, "stall",
                        1'b0, 32'h0, 1'b1);
                end
            end
            cyc(a, 1'b1, 1'b1, bd(cur_base, i),
                $sformatf("beat%0d", i), 1'b0, 32'h0, 1'b1);
        end
    endtask

    task automatic hit_line(input logic [31:0] base);
        for (int w = 0; w < 4; w++) begin
            hit(base + 32'(4 * w), bd(base, w),
                $sformatf("hit_%h_w%0d", base, w));
        end
    endtask

    initial begin
        tbl[0] = '{32'h0000_1008, 1'b0, 32'h0, 32'h3333_3333};
        tbl[1] = '{32'h0000_100C, 1'b0, 32'h0, 32'h4444_4444};
        tbl[2] = '{32'h0000_1000, 1'b0, 32'h0, 32'h1111_1111};
        tbl[3] = '{32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 32'h2222_2222};
        tbl[4] = '{32'h0000_100B, 1'b1, 32'hDEAD_BEEF, 32'h3333_3333};
        tbl[5] = '{32'h0000_1002, 1'b0, 32'h0, 32'h1111_1111};

        rst           = 1'b1;
        rdy           = 1'b1;
        bus.addr_in   = 32'h0;
        bus.mem_valid = 1'b0;
        bus.mem_data  = 32'h0;
        cur_base      = 32'h0;
        @(posedge clk);
        #1;
        cyc(32'h0000_1008, 1'b1, 1'b0, 32'h0, "reset",
            1'b0, 32'h0, 1'b0);
        rst = 1'b0;

        miss(32'h0000_1008, "cold_miss");
        fill(32'h0000_1008, 4'b1010, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(tbl[i].a, 1'b1, tbl[i].mv, tbl[i].md,
                $sformatf("tbl%0d", i), 1'b1, tbl[i].ed, 1'b0);
        end

        cyc(32'h0000_1008, 1'b0, 1'b0, 32'h0, "rdy_low_hit",
            1'b0, 32'h0, 1'b0);
        cyc(32'h0000_3000, 1'b0, 1'b0, 32'h0, "rdy_low_miss",
            1'b0, 32'h0, 1'b0);
        cyc(32'h0000_3000, 1'b0, 1'b1, 32'h0, "rdy_low_hold",
            1'b0, 32'h0, 1'b0);

        miss(32'h0000_1408, "conflict");
        fill(32'h0000_1408, 4'b0000, 0);
        hit_line(32'h0000_1400);
        miss(32'h0000_1008, "reconflict");
        fill(32'h0000_1008, 4'b0001, 0);
        hit_line(32'h0000_1000);

        miss(32'h0000_2040, "stall_miss");
        fill(32'h0000_2040, 4'b0000, 2);
        hit_line(32'h0000_2040);
        hit(32'h0000_1004, 32'h2222_2222, "other_idx");

        miss(32'h0000_6080, "rst_miss");
        cyc(32'h0000_6080, 1'b1, 1'b1, bd(cur_base, 0), "rb0",
            1'b0, 32'h0, 1'b1);
        cyc(32'h0000_6080, 1'b1, 1'b1, bd(cur_base, 1), "rb1",
            1'b0, 32'h0, 1'b1);
        rst = 1'b1;
        cyc(32'h0000_6080, 1'b1, 1'b0, 32'h0, "rst_cycle",
            1'b0, 32'h0, 1'b1);
        rst      = 1'b0;
        cur_base = 32'h0;
        miss(32'h0000_6080, "after_rst");
        fill(32'h0000_6080, 4'b0100, 0);
        hit_line(32'h0000_6080);
        miss(32'h0000_2044, "rst_cleared");
        fill(32'h0000_2044, 4'b0000, 0);
        hit_line(32'h0000_2040);

        miss(32'h0000_1000, "chg_miss");
        fill(32'h0000_2000, 4'b0010, 0);
        miss(32'h0000_2000, "chg_next");
        fill(32'h0000_2000, 4'b0000, 0);
        hit_line(32'h0000_2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL have parameter INDEX_W, default 6, number of index bits (2^INDEX_W lines).
REQ-002 The block SHALL have clk  input  1  clock, all state updates on rising edge.
REQ-003 The block SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have rdy  input  1  global enable; low freezes all state.
REQ-005 The block SHALL have addr_in  input  32  fetch address from the instruction fetcher (current pc).
REQ-006 The block SHALL have instr_valid  output  1  instr_out holds the word at addr_in this cycle.
REQ-007 The block SHALL have instr_out  output  32  instruction word for addr_in.
REQ-008 The block SHALL have mem_req  output  1  line-fill request to the memory controller.
REQ-009 The block SHALL have mem_addr  output  32  line base address of the fill.
REQ-010 The block SHALL have mem_valid  input  1  one fill beat delivered this cycle.
REQ-011 The block SHALL have mem_data  input  32  beat data, little-endian word.

Function
REQ-012 Organisation SHALL be direct-mapped: 16-byte lines of 4 words; word = addr[3:2], index = addr[3+INDEX_W:4], tag = addr[31:4+INDEX_W]; addr[1:0] ignored.
REQ-013 Per line storage SHALL be a valid bit, a tag and 4 data words.
REQ-014 States SHALL be IDLE and FILL; reset state IDLE.
REQ-015 Hit = IDLE, rdy high, line valid, stored tag equals tag of addr_in; hit SHALL be combinational (zero latency).
REQ-016 instr_valid SHALL equal hit; instr_out SHALL be the selected word on hit, don't-care otherwise.
REQ-017 instr_valid SHALL be 0 whenever state is FILL or rdy is low.
REQ-018 IDLE with rdy high and miss SHALL, at the next edge: latch fill address {addr_in[31:4],4'b0}, clear the target line's valid bit, zero beat counter, enter FILL.
REQ-019 mem_req SHALL be 1 exactly while state is FILL; mem_addr SHALL be the latched fill address, constant for the whole fill.
REQ-020 In FILL, each edge with rdy and mem_valid high SHALL write mem_data into word[beat] of the target line and increment the 2-bit beat counter.
REQ-021 Beats MAY be non-consecutive; cycles with mem_valid low SHALL change nothing.
REQ-022 On the edge accepting beat 3, the block SHALL write the tag, set valid, return to IDLE; mem_req low from the following cycle.
REQ-023 Changes of addr_in during FILL SHALL NOT affect the fill; after return to IDLE hit check uses current addr_in.
REQ-024 mem_valid while IDLE SHALL be ignored.
REQ-025 With rdy low, state, counter, arrays and latched address SHALL hold; mem_valid SHALL be ignored.
REQ-026 Miss latency SHALL be 1 cycle to mem_req plus 4 accepted beats; first hit on the refilled line in the cycle after beat 3.
REQ-027 A fill SHALL replace any prior line at that index (no write-back, cache is read-only).

Reset
REQ-028 On rst: all valid bits 0, state IDLE, beat counter 0, fill address 0; outputs mem_req=0, mem_addr=0, instr_valid=0; data/tag arrays need not be cleared.
REQ-029 rst during FILL SHALL abort immediately; the partially filled line SHALL remain invalid.
REQ-030 rst SHALL take priority over rdy.

Verification
REQ-031 Cold miss: after reset, addr_in=0x00001008 -> instr_valid 0, next cycle mem_req=1, mem_addr=0x00001000.
REQ-032 Fill then hit: beats 0x11111111,0x22222222,0x33333333,0x44444444 with gaps -> cycle after 4th beat mem_req=0, instr_valid=1, instr_out=0x33333333; addr_in=0x0000100C same cycle -> 0x44444444.
REQ-033 Conflict: after REQ-032, addr_in=0x00001408 (INDEX_W=6, same index, different tag) -> miss, fill to 0x00001400; then 0x00001008 misses again.
REQ-034 rdy stall: drop rdy mid-fill while mem_valid pulses -> beats ignored, counter held, instr_valid 0; fill resumes when rdy returns.
REQ-035 Reset mid-fill: rst after 2 beats -> mem_req 0 next cycle; re-access of line base -> miss and full 4-beat refill.
REQ-036 addr_in changed to 0x00002000 during fill of 0x00001000 -> fill completes at 0x00001000, then immediate miss fill for 0x00002000.
